// File: rtl/fir_lite_regs_if.sv
// rtl/fir_lite_regs_if.sv - AXI4-Lite register-port bundle for the FIR control registers
interface fir_lite_regs_if #(
  parameter int ADDR_W = 4
);
  logic              s_awvalid;
  logic              s_awready;
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_wvalid;
  logic              s_wready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_bvalid;
  logic              s_bready;
  logic [1:0]        s_bresp;
  logic              s_arvalid;
  logic              s_arready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_rvalid;
  logic              s_rready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    input  s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp,
    output s_arready, s_rvalid, s_rdata, s_rresp
  );

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    output s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp,
    input  s_arready, s_rvalid, s_rdata, s_rresp
  );
endinterface

// File: rtl/fir_lite_regs.sv
// rtl/fir_lite_regs.sv - AXI4-Lite slave holding FIR config/command/tap words with one-cycle write events
module fir_lite_regs #(
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fir_lite_regs_if.slave      s_axi,
  input  logic                cont_ready,
  output logic [1:0]          config_valid,
  output logic [31:0]         input_config,
  output logic [31:0]         input_command,
  output logic [31:0]         config_tap
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t    r_wstate, w_wstate_nxt;
  r_state_t    r_rstate, w_rstate_nxt;

  logic [1:0]  r_awidx;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_config_valid;
  logic [31:0] r_input_config;
  logic [31:0] r_input_command;
  logic [31:0] r_config_tap;

  logic        w_awready;
  logic        w_wready;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_wr_fire;
  logic [1:0]  w_wr_idx;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic        w_wr_err;
  logic        w_ar_hs;
  logic [31:0] w_rd_val;
  logic        w_unused_addr;

  assign w_awready = (r_wstate == W_IDLE) || (r_wstate == W_DATA);
  assign w_wready  = (r_wstate == W_IDLE) || (r_wstate == W_ADDR);
  assign w_aw_hs   = s_axi.s_awvalid && w_awready;
  assign w_w_hs    = s_axi.s_wvalid && w_wready;
  assign w_ar_hs   = s_axi.s_arvalid && (r_rstate == R_IDLE);

  // Low address bits only select bytes within a word, which this block ignores.
  assign w_unused_addr = ^{s_axi.s_awaddr, s_axi.s_araddr};

  // Completion may pair a held channel with a live one; pick each field from wherever it lives this cycle.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wr_fire    = 1'b0;
    w_wr_idx     = r_awidx;
    w_wr_data    = r_wdata;
    w_wr_strb    = r_wstrb;
    case (r_wstate)
      W_IDLE: begin
        if (s_axi.s_awvalid && s_axi.s_wvalid) begin
          w_wr_fire    = 1'b1;
          w_wr_idx     = s_axi.s_awaddr[3:2];
          w_wr_data    = s_axi.s_wdata;
          w_wr_strb    = s_axi.s_wstrb;
          w_wstate_nxt = W_RESP;
        end else if (s_axi.s_awvalid) begin
          w_wstate_nxt = W_ADDR;
        end else if (s_axi.s_wvalid) begin
          w_wstate_nxt = W_DATA;
        end
      end
      W_ADDR: begin
        if (s_axi.s_wvalid) begin
          w_wr_fire    = 1'b1;
          w_wr_data    = s_axi.s_wdata;
          w_wr_strb    = s_axi.s_wstrb;
          w_wstate_nxt = W_RESP;
        end
      end
      W_DATA: begin
        if (s_axi.s_awvalid) begin
          w_wr_fire    = 1'b1;
          w_wr_idx     = s_axi.s_awaddr[3:2];
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi.s_bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  assign w_wr_err = (w_wr_idx == 2'd0) || (w_wr_strb != 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate        <= W_IDLE;
      r_awidx         <= 2'd0;
      r_wdata         <= 32'd0;
      r_wstrb         <= 4'd0;
      r_bvalid        <= 1'b0;
      r_bresp         <= 2'b00;
      r_config_valid  <= 2'd0;
      r_input_config  <= 32'd0;
      r_input_command <= 32'd0;
      r_config_tap    <= 32'd0;
    end else begin
      r_wstate       <= w_wstate_nxt;
      r_config_valid <= 2'd0;
      if (w_aw_hs) r_awidx <= s_axi.s_awaddr[3:2];
      if (w_w_hs) begin
        r_wdata <= s_axi.s_wdata;
        r_wstrb <= s_axi.s_wstrb;
      end
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_err ? 2'b10 : 2'b00;
        if (!w_wr_err) begin
          r_config_valid <= w_wr_idx;
          case (w_wr_idx)
            2'd1:    r_input_config  <= w_wr_data;
            2'd2:    r_input_command <= w_wr_data;
            2'd3:    r_config_tap    <= w_wr_data;
            default: ;
          endcase
        end
      end else if ((r_wstate == W_RESP) && s_axi.s_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rd_val     = 32'd0;
    case (s_axi.s_araddr[3:2])
      2'd0:    w_rd_val = {31'd0, cont_ready};
      2'd1:    w_rd_val = r_input_config;
      2'd2:    w_rd_val = r_input_command;
      default: w_rd_val = r_config_tap;
    endcase
    case (r_rstate)
      R_IDLE:  if (s_axi.s_arvalid) w_rstate_nxt = R_DATA;
      R_DATA:  if (s_axi.s_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Register contents are sampled pre-edge, so a same-cycle write completion yields the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate <= R_IDLE;
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_val;
      end else if ((r_rstate == R_DATA) && s_axi.s_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s_axi.s_awready = w_awready;
  assign s_axi.s_wready  = w_wready;
  assign s_axi.s_bvalid  = r_bvalid;
  assign s_axi.s_bresp   = r_bresp;
  assign s_axi.s_arready = (r_rstate == R_IDLE);
  assign s_axi.s_rvalid  = r_rvalid;
  assign s_axi.s_rdata   = r_rdata;
  assign s_axi.s_rresp   = 2'b00;
  assign config_valid    = r_config_valid;
  assign input_config    = r_input_config;
  assign input_command   = r_input_command;
  assign config_tap      = r_config_tap;

endmodule

// File: tb/tb_fir_lite_regs.sv
// tb/tb_fir_lite_regs.sv - self-checking bench for fir_lite_regs with a register-array reference model
module tb_fir_lite_regs;
  logic        clk;
  logic        rst_n;
  logic        cont_ready;
  logic [1:0]  config_valid;
  logic [31:0] input_config;
  logic [31:0] input_command;
  logic [31:0] config_tap;

  int n_checks;
  int n_fail;
  logic [31:0] model [4];

  fir_lite_regs_if #(.ADDR_W(4)) bus ();

  fir_lite_regs #(.ADDR_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axi         (bus),
    .cont_ready    (cont_ready),
    .config_valid  (config_valid),
    .input_config  (input_config),
    .input_command (input_command),
    .config_tap    (config_tap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_bus();
    bus.s_awvalid = 1'b0; bus.s_awaddr = '0;
    bus.s_wvalid  = 1'b0; bus.s_wdata  = '0; bus.s_wstrb = '0;
    bus.s_bready  = 1'b0;
    bus.s_arvalid = 1'b0; bus.s_araddr = '0;
    bus.s_rready  = 1'b0;
  endtask

  task automatic drive_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, output logic [1:0] resp,
                             output int n_pulse, output logic [1:0] code, output bit ok);
    bit aw_done, w_done, a, w;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0; n_pulse = 0; code = 2'd0; ok = 0; resp = 2'b11;
    bus.s_bready = 1'b1;
    @(negedge clk);
    while (!(aw_done && w_done) && cyc < 50) begin
      bus.s_awvalid = !aw_done && (cyc >= aw_dly);
      bus.s_awaddr  = addr;
      bus.s_wvalid  = !w_done && (cyc >= w_dly);
      bus.s_wdata   = data;
      bus.s_wstrb   = strb;
      a = bus.s_awvalid && bus.s_awready;
      w = bus.s_wvalid && bus.s_wready;
      @(negedge clk);
      cyc++;
      aw_done |= a;
      w_done  |= w;
      if (config_valid != 2'd0) begin n_pulse++; code = config_valid; end
    end
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    if (aw_done && w_done && bus.s_bvalid) begin ok = 1; resp = bus.s_bresp; end
    repeat (2) begin
      @(negedge clk);
      if (config_valid != 2'd0) begin n_pulse++; code = config_valid; end
    end
  endtask

  task automatic drive_read(input logic [3:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output bit ok);
    bit done, a;
    int cyc;
    done = 0; cyc = 0;
    bus.s_rready = 1'b1;
    @(negedge clk);
    bus.s_arvalid = 1'b1;
    bus.s_araddr  = addr;
    while (!done && cyc < 50) begin
      a = bus.s_arready;
      @(negedge clk);
      cyc++;
      if (a) done = 1;
    end
    bus.s_arvalid = 1'b0;
    ok   = done && bus.s_rvalid;
    data = bus.s_rdata;
    resp = bus.s_rresp;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_bus();
    cont_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.s_bvalid, bus.s_rvalid, config_valid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_valids: got %b want 0000", {bus.s_bvalid, bus.s_rvalid, config_valid});
    end
    n_checks++;
    if ({input_config, input_command, config_tap, bus.s_rdata} !== 128'd0) begin
      n_fail++; $display("FAIL reset_regs: cfg=%h cmd=%h tap=%h rdata=%h want 0", input_config, input_command, config_tap, bus.s_rdata);
    end
    n_checks++;
    if ({bus.s_bresp, bus.s_rresp} !== 4'b0) begin
      n_fail++; $display("FAIL reset_resp: got %b want 0000", {bus.s_bresp, bus.s_rresp});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.s_awready, bus.s_wready, bus.s_arready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_readys: got %b want 111", {bus.s_awready, bus.s_wready, bus.s_arready});
    end
    for (int i = 0; i < 4; i++) model[i] = 32'd0;
  endtask

  task automatic test_config_write();
    @(negedge clk);
    bus.s_bready  = 1'b0;
    bus.s_awvalid = 1'b1; bus.s_awaddr = 4'h4;
    bus.s_wvalid  = 1'b1; bus.s_wdata  = 32'h8000_0805; bus.s_wstrb = 4'hF;
    @(negedge clk);
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    model[1] = 32'h8000_0805;
    n_checks++;
    if (config_valid !== 2'd1 || input_config !== model[1]) begin
      n_fail++; $display("FAIL cfg_pulse: cv=%0d cfg=%h want 1 %h", config_valid, input_config, model[1]);
    end
    n_checks++;
    if (bus.s_bvalid !== 1'b1 || bus.s_bresp !== 2'b00 || bus.s_awready !== 1'b0 || bus.s_wready !== 1'b0) begin
      n_fail++; $display("FAIL cfg_resp: bvalid=%b bresp=%b awr=%b wr=%b want 1 00 0 0", bus.s_bvalid, bus.s_bresp, bus.s_awready, bus.s_wready);
    end
    bus.s_bready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (config_valid !== 2'd0 || bus.s_bvalid !== 1'b0) begin
      n_fail++; $display("FAIL cfg_after: cv=%0d bvalid=%b want 0 0", config_valid, bus.s_bvalid);
    end
  endtask

  task automatic test_split_write();
    bit bad;
    @(negedge clk);
    bus.s_bready = 1'b1;
    bus.s_wvalid = 1'b1; bus.s_wdata = 32'd1; bus.s_wstrb = 4'hF;
    bad = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.s_wvalid = 1'b0;
      if (bus.s_wready !== 1'b0 || config_valid !== 2'd0 || bus.s_bvalid !== 1'b0) bad = 1;
      if (c == 3) begin bus.s_awvalid = 1'b1; bus.s_awaddr = 4'h8; end
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL split_wait: wready/cv/bvalid not idle in cycles 1-3, got bad=%b want 0", bad); end
    @(negedge clk);
    bus.s_awvalid = 1'b0;
    model[2] = 32'd1;
    n_checks++;
    if (config_valid !== 2'd2 || input_command !== model[2] || bus.s_bvalid !== 1'b1) begin
      n_fail++; $display("FAIL split_pulse: cv=%0d cmd=%h bvalid=%b want 2 %h 1", config_valid, input_command, bus.s_bvalid, model[2]);
    end
    @(negedge clk);
    n_checks++;
    if (config_valid !== 2'd0) begin n_fail++; $display("FAIL split_after: cv=%0d want 0", config_valid); end
  endtask

  task automatic test_slverr();
    logic [1:0] resp, code;
    int np;
    bit ok;
    drive_write(4'h0, 32'hDEAD_BEEF, 4'hF, 0, 0, resp, np, code, ok);
    n_checks++;
    if (!ok || resp !== 2'b10 || np !== 0) begin
      n_fail++; $display("FAIL slverr_reg0: ok=%b resp=%b pulses=%0d want 1 10 0", ok, resp, np);
    end
    drive_write(4'hC, 32'h1234_5678, 4'h3, 1, 0, resp, np, code, ok);
    n_checks++;
    if (!ok || resp !== 2'b10 || np !== 0 || config_tap !== model[3]) begin
      n_fail++; $display("FAIL slverr_strb: ok=%b resp=%b pulses=%0d tap=%h want 1 10 0 %h", ok, resp, np, config_tap, model[3]);
    end
  endtask

  task automatic test_read_stall();
    bit bad;
    cont_ready = 1'b1;
    @(negedge clk);
    bus.s_rready  = 1'b0;
    bus.s_arvalid = 1'b1; bus.s_araddr = 4'h0;
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.s_rvalid !== 1'b1 || bus.s_rdata !== 32'd1 || bus.s_arready !== 1'b0 || bus.s_rresp !== 2'b00) bad = 1;
      cont_ready = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL read_stall: rvalid=%b rdata=%h arready=%b want 1 1 0", bus.s_rvalid, bus.s_rdata, bus.s_arready); end
    bus.s_rready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.s_rvalid !== 1'b0 || bus.s_arready !== 1'b1) begin
      n_fail++; $display("FAIL read_release: rvalid=%b arready=%b want 0 1", bus.s_rvalid, bus.s_arready);
    end
  endtask

  task automatic test_bready_stall();
    logic [1:0] resp, code;
    int np, pulses;
    bit ok, bad;
    @(negedge clk);
    bus.s_bready  = 1'b0;
    bus.s_awvalid = 1'b1; bus.s_awaddr = 4'hC;
    bus.s_wvalid  = 1'b1; bus.s_wdata  = 32'hCAFE_0001; bus.s_wstrb = 4'hF;
    @(negedge clk);
    model[3] = 32'hCAFE_0001;
    bus.s_awaddr = 4'h4; bus.s_wdata = 32'hBAD0_BAD0;
    pulses = 0; bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (config_valid != 2'd0) pulses++;
      if (bus.s_bvalid !== 1'b1 || bus.s_awready !== 1'b0 || bus.s_wready !== 1'b0) bad = 1;
    end
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    n_checks++;
    if (bad || pulses != 0 || config_tap !== model[3] || input_config !== model[1]) begin
      n_fail++; $display("FAIL bready_stall: bad=%b pulses=%0d tap=%h cfg=%h want 0 0 %h %h", bad, pulses, config_tap, input_config, model[3], model[1]);
    end
    bus.s_bready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.s_bvalid !== 1'b0) begin n_fail++; $display("FAIL bready_release: bvalid=%b want 0", bus.s_bvalid); end
    drive_write(4'h4, 32'h0000_00A5, 4'hF, 0, 0, resp, np, code, ok);
    model[1] = 32'h0000_00A5;
    n_checks++;
    if (!ok || resp !== 2'b00 || np !== 1 || code !== 2'd1 || input_config !== model[1]) begin
      n_fail++; $display("FAIL back_to_back: ok=%b resp=%b pulses=%0d code=%0d cfg=%h want 1 00 1 1 %h", ok, resp, np, code, input_config, model[1]);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    @(negedge clk);
    bus.s_bready  = 1'b1;
    bus.s_awvalid = 1'b1; bus.s_awaddr = 4'hC;
    @(negedge clk);
    bus.s_awvalid = 1'b0;
    rst_n = 1'b0;
    bus.s_wvalid = 1'b1; bus.s_wdata = 32'h5555_AAAA; bus.s_wstrb = 4'hF;
    repeat (2) @(negedge clk);
    bus.s_wvalid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 32'd0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (config_valid !== 2'd0 || bus.s_bvalid !== 1'b0 || bus.s_rvalid !== 1'b0) bad = 1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL reset_mid_quiet: response or pulse after aborted write, got bad=%b want 0", bad); end
    n_checks++;
    if ({input_config, input_command, config_tap, bus.s_rdata} !== 128'd0 ||
        {bus.s_awready, bus.s_wready, bus.s_arready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_mid_state: cfg=%h cmd=%h tap=%h readys=%b want 0 0 0 111", input_config, input_command, config_tap, {bus.s_awready, bus.s_wready, bus.s_arready});
    end
  endtask

  task automatic test_random();
    logic [1:0]  resp, code, idx;
    logic [31:0] data, exp_data;
    logic [3:0]  strb;
    int np;
    bit ok, err;
    for (int it = 0; it < 60; it++) begin
      idx = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        data = $urandom;
        strb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        err  = (idx == 2'd0) || (strb != 4'hF);
        drive_write({idx, 2'($urandom)}, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), resp, np, code, ok);
        if (!err) model[idx] = data;
        n_checks++;
        if (!ok || resp !== (err ? 2'b10 : 2'b00) || np !== (err ? 0 : 1) || (!err && code !== idx)) begin
          n_fail++; $display("FAIL rand_write it=%0d: ok=%b resp=%b pulses=%0d code=%0d want err=%b idx=%0d", it, ok, resp, np, code, err, idx);
        end
        n_checks++;
        if (input_config !== model[1] || input_command !== model[2] || config_tap !== model[3]) begin
          n_fail++; $display("FAIL rand_regs it=%0d: got %h %h %h want %h %h %h", it, input_config, input_command, config_tap, model[1], model[2], model[3]);
        end
      end else begin
        cont_ready = 1'($urandom);
        exp_data = (idx == 2'd0) ? {31'd0, cont_ready} : model[idx];
        drive_read({idx, 2'($urandom)}, data, resp, ok);
        n_checks++;
        if (!ok || data !== exp_data || resp !== 2'b00) begin
          n_fail++; $display("FAIL rand_read it=%0d idx=%0d: ok=%b data=%h resp=%b want %h 00", it, idx, ok, data, resp, exp_data);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_config_write();
    test_split_write();
    test_slverr();
    test_read_stall();
    test_bready_stall();
    test_random();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_lite_regs.md
FIR_LITE_REGS -- requirements
Module: fir_lite_regs

Interface
REQ-001 Parameter: ADDR_W, 4, AXI4-Lite byte-address width; DATA_W fixed at 32.
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 s_awvalid/s_awready  in/out  1  write-address handshake; s_awaddr  in  ADDR_W.
REQ-005 s_wvalid/s_wready  in/out  1  write-data handshake; s_wdata  in  32; s_wstrb  in  4.
REQ-006 s_bvalid/s_bready  out/in  1  write-response handshake; s_bresp  out  2.
REQ-007 s_arvalid/s_arready  in/out  1  read-address handshake; s_araddr  in  ADDR_W.
REQ-008 s_rvalid/s_rready  out/in  1  read-data handshake; s_rdata  out  32; s_rresp  out  2.
REQ-009 cont_ready  in  1  FIR controller idle/ready status.
REQ-010 config_valid  out  2  one-cycle write-event code to controller: 0 none, 1 config, 2 command, 3 tap.
REQ-011 input_config, input_command, config_tap  out  32 each  last accepted word for reg 1, 2, 3.

Function
REQ-012 Register map, word index = addr[3:2], addr[1:0] ignored: 0 status (RO, bit0 = cont_ready, rest 0), 1 config, 2 command, 3 tap.
REQ-013 Write FSM states W_IDLE, W_ADDR (AW held, awaiting W), W_DATA (W held, awaiting AW), W_RESP.
REQ-014 s_awready = 1 in W_IDLE and W_DATA only; s_wready = 1 in W_IDLE and W_ADDR only; both 0 in W_RESP.
REQ-015 W_IDLE: AW and W same cycle -> W_RESP; AW only -> W_ADDR (latch addr); W only -> W_DATA (latch data, strb).
REQ-016 On completion edge (entry to W_RESP): s_bvalid = 1, target register loaded, config_valid = code of target, all simultaneously.
REQ-017 config_valid returns to 0 on the following edge; never asserted for more than one cycle per write.
REQ-018 W_RESP: hold s_bvalid and s_bresp until s_bready; on handshake -> W_IDLE, s_bvalid = 0 next edge; next write accepted earliest one cycle later.
REQ-019 Write to reg 0, or s_wstrb != 4'hF: s_bresp = 2'b10 (SLVERR), no register update, config_valid stays 0.
REQ-020 Legal write: s_bresp = 2'b00 (OKAY).
REQ-021 Read FSM states R_IDLE, R_DATA; s_arready = 1 only in R_IDLE.
REQ-022 AR handshake -> next edge s_rvalid = 1, s_rdata = addressed value (status sampled at handshake cycle), s_rresp = 2'b00, state R_DATA.
REQ-023 R_DATA: hold s_rdata/s_rvalid until s_rready; then R_IDLE, s_rvalid = 0 next edge.
REQ-024 Read and write channels independent; a read of a register in the same cycle as its write completion returns the old value.
REQ-025 All outputs registered; no combinational path from any input to any output except none (readys derive from state only).

Reset
REQ-026 rst_n low: both FSMs idle, s_bvalid = s_rvalid = 0, s_awready = s_wready = s_arready = 1 after release, config_valid = 0, input_config = input_command = config_tap = 0, s_rdata = 0, s_bresp = s_rresp = 0.
REQ-027 Reset mid-transaction aborts it; no config_valid pulse or response issued for the aborted transfer.

Verification
REQ-028 Write 0x8000_0805 to addr 0x4, AW and W together -> one cycle later config_valid = 1, input_config = 0x8000_0805, s_bvalid = 1, s_bresp = 0; pulse gone next cycle.
REQ-029 W at cycle 0, AW (addr 0x8, data 1) at cycle 3 -> s_awready low cycles 1-3 not required, s_wready low cycles 1-3; config_valid = 2 at cycle 4 only.
REQ-030 Write addr 0x0 or wstrb = 4'h3 to addr 0xC -> s_bresp = 2'b10, config_valid stays 0, config_tap unchanged.
REQ-031 cont_ready = 1, read addr 0x0 with s_rready held low 5 cycles -> s_rvalid = 1, s_rdata = 1 stable all 5 cycles, s_arready = 0 throughout.
REQ-032 s_bready held low 10 cycles after write -> s_bvalid stays 1, no second pulse, new AW/W not accepted until after handshake.
REQ-033 Assert rst_n low between AW and W handshakes -> after release all outputs at reset values, no config_valid pulse.
